data_mem_periph: RTL
====================

DATA_MEM_PERIPH -- requirements
Module: data_mem_periph

Interface
REQ-001 SHALL have parameter RAM_WORDS, default 256, giving data RAM depth in 32-bit words (power of two, 16..1024).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port addr, input, 32 bits: byte address from the EX_MEM ALU result.
REQ-005 SHALL have port wdata, input, 32 bits: store data.
REQ-006 SHALL have port MemRead, input, 1 bit: load request this cycle.
REQ-007 SHALL have port MemWrite, input, 1 bit: store request this cycle.
REQ-008 SHALL have port rdata, output, 32 bits: load data (memreaddataMEM, to MEM_WB).
REQ-009 SHALL have port irq, output, 1 bit: timer interrupt request (to MEM_WB/control intterupt).
REQ-010 SHALL have port leds, output, 8 bits: LED register.
REQ-011 SHALL have port digits, output, 12 bits: 7-segment register.

Function
REQ-012 Memory map SHALL be: 0x00000000-(4*RAM_WORDS-4) RAM; 0x40000000 TH; 0x40000004 TL; 0x40000008 TCON[2:0]; 0x4000000C LEDs[7:0]; 0x40000010 digits[11:0]; 0x40000014 systick (read-only).
REQ-013 RAM SHALL be word-addressed by addr[log2(RAM_WORDS)+1:2]; addr[1:0] ignored on all accesses.
REQ-014 Reads SHALL be combinational: rdata valid in the same cycle as MemRead, zero-latency, so MEM_WB captures it at the next edge.
REQ-015 rdata SHALL be 0 when MemRead=0 or addr is unmapped; narrow registers SHALL read zero-extended.
REQ-016 Writes SHALL take effect at the rising edge where MemWrite=1; unmapped or systick writes SHALL be ignored.
REQ-017 A read and write to the same address in one cycle SHALL return the old value.
REQ-018 TCON bit0 = timer enable, bit1 = interrupt enable, bit2 = interrupt status.
REQ-019 When TCON[0]=1, TL SHALL increment by 1 each cycle; when TL=0xFFFFFFFF it SHALL load TH instead and set TCON[2] if TCON[1]=1.
REQ-020 irq SHALL equal TCON[1] AND TCON[2], registered (no combinational path from inputs).
REQ-021 TCON[2] SHALL stay set until software writes TCON with bit2=0.
REQ-022 Simultaneous CPU write to TL and timer increment/reload: CPU write SHALL win.
REQ-023 Simultaneous CPU write to TCON and overflow status set: CPU write value SHALL win.
REQ-024 systick SHALL increment every cycle unconditionally, wrapping 0xFFFFFFFF->0.
REQ-025 leds and digits SHALL drive their register values directly.

Reset
REQ-026 On reset at a rising edge: TH, TL, TCON, LEDs, digits, systick SHALL become 0; irq SHALL be 0 from the following cycle.
REQ-027 Reset SHALL take priority over any write or timer event in the same cycle, including mid-count.
REQ-028 RAM contents SHALL NOT be reset.

Structure
REQ-029 Address constants and TCON bit indices SHALL live in shared package mips_mem_pkg.
REQ-030 Timer (TH, TL, TCON, irq) SHALL be sub-module timer_unit; RAM, decode and other registers stay in the top.

Verification
REQ-031 Store 0xDEADBEEF to 0x10, load 0x10 next cycle -> rdata=0xDEADBEEF; load 0x13 -> same value.
REQ-032 Load 0x50000000 with MemRead=1 -> rdata=0; store there -> no register or RAM change.
REQ-033 TH=0xFFFFFFF0, TL=0xFFFFFFFE, TCON=3 -> TL reads 0xFFFFFFFF next cycle, 0xFFFFFFF0 after, irq=1 the cycle after reload edge.
REQ-034 With irq=1, write TCON=3 -> irq=0 next cycle; write TCON=1 at the overflow edge -> irq stays 0.
REQ-035 Timer counting with TCON=3, assert reset one cycle -> TL=TCON=systick=0, irq=0, RAM word 0x10 still 0xDEADBEEF.
REQ-036 Write LEDs=0x1A5 -> leds=0xA5; write digits=0xF123 -> digits=0x123; read back zero-extended.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared address map, TCON bit positions and decode helper
// for the MEM-stage data memory and peripheral block.
package mips_mem_pkg;

    localparam logic [31:0] ADDR_TH      = 32'h4000_0000;
    localparam logic [31:0] ADDR_TL      = 32'h4000_0004;
    localparam logic [31:0] ADDR_TCON    = 32'h4000_0008;
    localparam logic [31:0] ADDR_LEDS    = 32'h4000_000C;
    localparam logic [31:0] ADDR_DIGITS  = 32'h4000_0010;
    localparam logic [31:0] ADDR_SYSTICK = 32'h4000_0014;

    localparam int TCON_EN = 0;
    localparam int TCON_IE = 1;
    localparam int TCON_IS = 2;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_RAM,
        SEL_TH,
        SEL_TL,
        SEL_TCON,
        SEL_LEDS,
        SEL_DIGITS,
        SEL_SYSTICK
    } sel_e;

    // Byte offset within a word never affects which target is hit.
    function automatic sel_e mem_decode(
        input logic [31:0] addr,
        input logic [31:0] ram_bytes
    );
        logic [31:0] wa;
        sel_e        sel;
        wa  = {addr[31:2], 2'b00};
        sel = SEL_NONE;
        if (addr < ram_bytes) begin
            sel = SEL_RAM;
        end else begin
            case (wa)
                ADDR_TH:      sel = SEL_TH;
                ADDR_TL:      sel = SEL_TL;
                ADDR_TCON:    sel = SEL_TCON;
                ADDR_LEDS:    sel = SEL_LEDS;
                ADDR_DIGITS:  sel = SEL_DIGITS;
                ADDR_SYSTICK: sel = SEL_SYSTICK;
                default:      sel = SEL_NONE;
            endcase
        end
        return sel;
    endfunction

endpackage

// File: rtl/timer_unit.sv
// Reloading 32-bit timer with sticky overflow status and
// a registered interrupt request; CPU writes beat timer events.
module timer_unit
    import mips_mem_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_th,
    input  logic        wr_tl,
    input  logic        wr_tcon,
    input  logic [31:0] wdata,
    output logic [31:0] th,
    output logic [31:0] tl,
    output logic [2:0]  tcon,
    output logic        irq
);

    logic [31:0] th_q, th_d;
    logic [31:0] tl_q, tl_d;
    logic [2:0]  tcon_q, tcon_d;
    logic        irq_q, irq_d;

    always_comb begin
        th_d   = th_q;
        tl_d   = tl_q;
        tcon_d = tcon_q;
        if (tcon_q[TCON_EN]) begin
            if (tl_q == 32'hFFFF_FFFF) begin
                tl_d = th_q;
                if (tcon_q[TCON_IE]) begin
                    tcon_d[TCON_IS] = 1'b1;
                end
            end else begin
                tl_d = tl_q + 32'd1;
            end
        end
        if (wr_th) begin
            th_d = wdata;
        end
        if (wr_tl) begin
            tl_d = wdata;
        end
        if (wr_tcon) begin
            tcon_d = wdata[2:0];
        end
        // irq tracks the committed TCON value of the same edge.
        irq_d = tcon_d[TCON_IE] & tcon_d[TCON_IS];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            th_q   <= '0;
            tl_q   <= '0;
            tcon_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            th_q   <= th_d;
            tl_q   <= tl_d;
            tcon_q <= tcon_d;
            irq_q  <= irq_d;
        end
    end

    assign th   = th_q;
    assign tl   = tl_q;
    assign tcon = tcon_q;
    assign irq  = irq_q;

endmodule

// File: rtl/data_mem_periph.sv
// MEM-stage data RAM plus memory-mapped timer, LEDs, digits
// and free-running systick; loads are combinational.
module data_mem_periph
    import mips_mem_pkg::*;
#(
    parameter int RAM_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        MemRead,
    input  logic        MemWrite,
    output logic [31:0] rdata,
    output logic        irq,
    output logic [7:0]  leds,
    output logic [11:0] digits
);

    localparam int          AW        = $clog2(RAM_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(4 * RAM_WORDS);

    logic [31:0] ram_q [RAM_WORDS];
    logic [7:0]  leds_q, leds_d;
    logic [11:0] digits_q, digits_d;
    logic [31:0] systick_q, systick_d;
    logic [31:0] th, tl;
    logic [2:0]  tcon;
    logic [AW-1:0] ram_idx;
    sel_e        sel;
    logic        ram_we;
    logic [31:0] rdata_c;

    assign sel     = mem_decode(addr, RAM_BYTES);
    assign ram_idx = addr[AW+1:2];
    assign ram_we  = MemWrite && (sel == SEL_RAM);

    timer_unit u_timer (
        .clk     (clk),
        .reset   (reset),
        .wr_th   (MemWrite && (sel == SEL_TH)),
        .wr_tl   (MemWrite && (sel == SEL_TL)),
        .wr_tcon (MemWrite && (sel == SEL_TCON)),
        .wdata   (wdata),
        .th      (th),
        .tl      (tl),
        .tcon    (tcon),
        .irq     (irq)
    );

    always_comb begin
        rdata_c = '0;
        if (MemRead) begin
            case (sel)
                SEL_RAM:     rdata_c = ram_q[ram_idx];
                SEL_TH:      rdata_c = th;
                SEL_TL:      rdata_c = tl;
                SEL_TCON:    rdata_c = {29'd0, tcon};
                SEL_LEDS:    rdata_c = {24'd0, leds_q};
                SEL_DIGITS:  rdata_c = {20'd0, digits_q};
                SEL_SYSTICK: rdata_c = systick_q;
                default:     rdata_c = '0;
            endcase
        end
    end

    always_comb begin
        leds_d    = leds_q;
        digits_d  = digits_q;
        systick_d = systick_q + 32'd1;
        if (MemWrite && (sel == SEL_LEDS)) begin
            leds_d = wdata[7:0];
        end
        if (MemWrite && (sel == SEL_DIGITS)) begin
            digits_d = wdata[11:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            leds_q    <= '0;
            digits_q  <= '0;
            systick_q <= '0;
        end else begin
            leds_q    <= leds_d;
            digits_q  <= digits_d;
            systick_q <= systick_d;
        end
    end

    // RAM keeps its contents across reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram_q[ram_idx] <= wdata;
        end
    end

    assign rdata  = rdata_c;
    assign leds   = leds_q;
    assign digits = digits_q;

endmodule
